key_schedule_engine: RTL and testbench

Word-serial AES key expansion engine supporting 128-, 192- and 256-bit cipher keys, selected at run time and bounded by a build-time parameter. On a start handshake it expands the key one 32-bit word per cycle using four `sbox` instances and an iterative Rcon generator. It streams the Nr+1 round keys (index 0..Nr) over a valid/ready interface with backpressure, so the cipher datapath can consume keys on the fly instead of holding a full combinational expansion per round.

---
 rtl/key_schedule_engine.sv | 215 +++++++++++++++++++++
 tb/tb_key_schedule_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_engine.sv
// AES key expansion engine (128/192/256-bit keys), one 32-bit word per cycle.
// Round keys are streamed over a valid/ready port with backpressure.

// Forward AES S-box computed as GF(2^8) inverse (x^254) plus the affine map.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(x, x);
    acc = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;
  assign inv = ginv(a);
  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module key_schedule_engine #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic         flush,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);
  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t      state_reg;
  logic [31:0] win_reg [MAX_NK];   // win_reg[MAX_NK-1] is the newest word
  logic [95:0] asm_reg;            // first three words of the round key being built
  logic [5:0]  i_reg;              // word counter
  logic [2:0]  m_reg;              // i mod Nk
  logic [7:0]  rc_reg;
  logic [3:0]  nk_reg;
  logic [3:0]  nr_reg;

  logic [3:0]  nk_new;
  logic [3:0]  nr_new;
  logic        len_ok;
  logic [31:0] key_w [8];
  logic [31:0] prev_w;
  logic [31:0] old_w;
  logic [31:0] sb_in;
  logic [31:0] sb_out;
  logic [31:0] word;
  logic        first_pass;
  logic        stall;
  logic        produce;

  // Key words, w0 in the top 32 bits
  for (genvar gi = 0; gi < 8; gi++) begin : g_key_w
    assign key_w[gi] = key[255-32*gi -: 32];
  end

  // Mode decode for a start request
  always_comb begin
    nk_new = 4'd0;
    nr_new = 4'd0;
    case (key_len)
      2'b00:   begin nk_new = 4'd4; nr_new = 4'd10; end
      2'b01:   begin nk_new = 4'd6; nr_new = 4'd12; end
      2'b10:   begin nk_new = 4'd8; nr_new = 4'd14; end
      default: begin nk_new = 4'd0; nr_new = 4'd0; end
    endcase
  end
  assign len_ok = (key_len != 2'b11) && (int'(nk_new) <= MAX_NK);

  // Select w[i-Nk] from the window; during the first pass this recirculates the key
  always_comb begin
    old_w = 32'h0;
    for (int k = 0; k < MAX_NK; k++) begin
      if (k == MAX_NK - int'(nk_reg)) old_w = win_reg[k];
    end
  end

  assign prev_w     = win_reg[MAX_NK-1];
  assign first_pass = (i_reg < 6'(nk_reg));
  // The four S-boxes serve both SubWord(RotWord(t)) and plain SubWord(t)
  assign sb_in      = (m_reg == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    sbox u_sbox (.a(sb_in[8*gi +: 8]), .y(sb_out[8*gi +: 8]));
  end

  // Next expanded word w[i]
  always_comb begin
    word = old_w ^ prev_w;
    if (first_pass)                            word = old_w;
    else if (m_reg == 3'd0)                    word = old_w ^ sb_out ^ {rc_reg, 24'h0};
    else if (nk_reg == 4'd8 && m_reg == 3'd4)  word = old_w ^ sb_out;
  end

  // The word that completes a round key cannot be produced while the previous key is unaccepted
  assign stall   = rk_valid && !rk_ready && (i_reg[1:0] == 2'b11);
  assign produce = (state_reg == GEN) && !stall;

  // Control FSM, word window, assembly and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      rk_idx    <= '0;
      rk_last   <= 1'b0;
      asm_reg   <= '0;
      i_reg     <= '0;
      m_reg     <= '0;
      rc_reg    <= '0;
      nk_reg    <= '0;
      nr_reg    <= '0;
      for (int k = 0; k < MAX_NK; k++) win_reg[k] <= '0;
    end else begin
      err <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
        rk_valid  <= 1'b0;
        rk_last   <= 1'b0;
        i_reg     <= '0;
        m_reg     <= '0;
        rc_reg    <= '0;
      end else begin
        if (rk_valid && rk_ready) begin
          rk_valid <= 1'b0;
          rk_last  <= 1'b0;
        end
        case (state_reg)
          IDLE: begin
            if (start) begin
              if (len_ok) begin
                state_reg <= GEN;
                busy      <= 1'b1;
                nk_reg    <= nk_new;
                nr_reg    <= nr_new;
                i_reg     <= '0;
                m_reg     <= '0;
                rc_reg    <= 8'h01;
                for (int k = 0; k < MAX_NK; k++) begin
                  if (k >= MAX_NK - int'(nk_new))
                    win_reg[k] <= key_w[3'(k - MAX_NK + int'(nk_new))];
                  else
                    win_reg[k] <= '0;
                end
              end else begin
                err <= 1'b1;
              end
            end
          end
          GEN: begin
            if (produce) begin
              for (int k = 0; k < MAX_NK - 1; k++) win_reg[k] <= win_reg[k+1];
              win_reg[MAX_NK-1] <= word;
              i_reg <= i_reg + 6'd1;
              m_reg <= (m_reg == 3'(nk_reg - 4'd1)) ? 3'd0 : m_reg + 3'd1;
              if (!first_pass && m_reg == 3'd0)
                rc_reg <= {rc_reg[6:0], 1'b0} ^ (rc_reg[7] ? 8'h1b : 8'h00);
              case (i_reg[1:0])
                2'b00: asm_reg[95:64] <= word;
                2'b01: asm_reg[63:32] <= word;
                2'b10: asm_reg[31:0]  <= word;
                default: begin
                  rk_data  <= {asm_reg, word};
                  rk_idx   <= i_reg[5:2];
                  rk_last  <= (i_reg[5:2] == nr_reg);
                  rk_valid <= 1'b1;
                end
              endcase
              if (i_reg == {nr_reg, 2'b11}) state_reg <= DRAIN;
            end
          end
          DRAIN: begin
            if (rk_valid && rk_ready) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_key_schedule_engine.sv
// Directed bench for key_schedule_engine: FIPS-197 vectors, backpressure,
// error/ignore cases, flush and asynchronous reset recovery.
module tb_key_schedule_engine;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         flush;
  logic         rk_ready;
  logic         busy, err, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy4, err4, rk_valid4, rk_last4;
  logic [127:0] rk_data4;
  logic [3:0]   rk_idx4;

  key_schedule_engine #(.MAX_NK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .flush(flush), .busy(busy), .err(err), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  key_schedule_engine #(.MAX_NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .flush(flush), .busy(busy4), .err(err4), .rk_valid(rk_valid4),
    .rk_ready(rk_ready), .rk_data(rk_data4), .rk_idx(rk_idx4), .rk_last(rk_last4)
  );

  // Low 128 bits of the AES-128 key are junk that must be ignored
  logic [255:0] k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0123456789abcdeffeedface};
  logic [255:0] k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
  logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [127:0] r1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  logic [127:0] r10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic [127:0] r12_192 = 128'he98ba06f448c773c8ecc720401002202;
  logic [127:0] r14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit rand_mode = 0;

  logic [127:0] cap_data [512];
  logic [3:0]   cap_idx  [512];
  logic         cap_last [512];
  int           cap_cyc  [512];
  int           n = 0;
  int           vcnt = 0;
  int           busy_fall = 0;
  logic         busy_q = 0;
  logic         hold_q = 0;
  logic [132:0] held = '0;
  logic [127:0] ref_keys [3][15];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Transfer capture, busy-fall timing and stall stability monitor
  always @(negedge clk) begin
    if (hold_q && rst_n && !flush)
      chk("stable", {rk_valid, rk_data, rk_idx, rk_last}, {1'b1, held});
    if (rk_valid && rk_ready) begin
      cap_data[n] <= rk_data;
      cap_idx[n]  <= rk_idx;
      cap_last[n] <= rk_last;
      cap_cyc[n]  <= cyc - t0;
      n <= n + 1;
    end
    if (rk_valid) vcnt <= vcnt + 1;
    if (busy_q && !busy) busy_fall <= cyc - t0;
    busy_q <= busy;
    hold_q <= rk_valid && !rk_ready;
    held   <= {rk_data, rk_idx, rk_last};
  end

  // Consumer ready: tied high or ~30% duty
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in cycle 1 of the new expansion
  task automatic start_key(input logic [1:0] len, input logic [255:0] k);
    @(posedge clk); #1;
    key_len = len;
    key     = k;
    start   = 1'b1;
    t0      = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_in_budget", c < budget, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_seq(input string tag, input int mode, input int base);
    int nr;
    nr = 10 + 2 * mode;
    chk({tag, "_count"}, n - base, nr + 1);
    for (int r = 0; r <= nr; r++) begin
      chk({tag, "_data"}, cap_data[base+r], ref_keys[mode][r]);
      chk({tag, "_idx"},  cap_idx[base+r], r);
      chk({tag, "_last"}, cap_last[base+r], r == nr);
    end
  endtask

  initial begin
    int base;
    int vb;
    rst_n = 0; start = 0; flush = 0; key_len = 2'b00; key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_valid", rk_valid, 1'b0);
    chk("rst_data", rk_data, 128'h0);
    chk("rst_idx", rk_idx, 4'h0);
    chk("rst_last", rk_last, 1'b0);
    rst_n = 1;
    step();

    // AES-128, ready tied high
    base = n; vb = vcnt;
    start_key(2'b00, k128);
    chk("a128_busy_c1", busy, 1'b1);
    wait_idle(3000);
    chk("a128_count", n - base, 11);
    chk("a128_r0", cap_data[base], k128[255:128]);
    chk("a128_r0_cyc", cap_cyc[base], 5);
    chk("a128_r1", cap_data[base+1], r1_128);
    chk("a128_r1_cyc", cap_cyc[base+1], 9);
    chk("a128_r10", cap_data[base+10], r10_128);
    chk("a128_r10_idx", cap_idx[base+10], 4'd10);
    chk("a128_r10_last", cap_last[base+10], 1'b1);
    chk("a128_r10_cyc", cap_cyc[base+10], 45);
    chk("a128_busy_fall", busy_fall, 46);
    chk("a128_valid_cycles", vcnt - vb, 11);
    chk("a128_nk4_build_r10", rk_data4, r10_128);
    for (int r = 0; r < 11; r++) begin
      chk("a128_idx", cap_idx[base+r], r);
      chk("a128_last", cap_last[base+r], r == 10);
      ref_keys[0][r] = cap_data[base+r];
    end

    // AES-192, ready tied high
    base = n;
    start_key(2'b01, k192);
    wait_idle(3000);
    chk("a192_count", n - base, 13);
    chk("a192_r0", cap_data[base], k192[255:128]);
    chk("a192_r12", cap_data[base+12], r12_192);
    chk("a192_r12_idx", cap_idx[base+12], 4'd12);
    chk("a192_r12_last", cap_last[base+12], 1'b1);
    chk("a192_r12_cyc", cap_cyc[base+12], 53);
    chk("a192_busy_fall", busy_fall, 54);
    for (int r = 0; r < 13; r++) ref_keys[1][r] = cap_data[base+r];

    // AES-256, ready tied high; the MAX_NK=4 build must reject it
    base = n;
    start_key(2'b10, k256);
    chk("a256_err_main", err, 1'b0);
    chk("nk4_err", err4, 1'b1);
    chk("nk4_busy", busy4, 1'b0);
    wait_idle(3000);
    chk("a256_count", n - base, 15);
    chk("a256_r0", cap_data[base], k256[255:128]);
    chk("a256_r1", cap_data[base+1], k256[127:0]);
    chk("a256_r14", cap_data[base+14], r14_256);
    chk("a256_r14_last", cap_last[base+14], 1'b1);
    chk("a256_r14_cyc", cap_cyc[base+14], 61);
    for (int r = 0; r < 15; r++) ref_keys[2][r] = cap_data[base+r];

    // Backpressure on all three modes
    rand_mode = 1;
    base = n; start_key(2'b00, k128); wait_idle(3000); check_seq("bp128", 0, base);
    base = n; start_key(2'b01, k192); wait_idle(3000); check_seq("bp192", 1, base);
    base = n; start_key(2'b10, k256); wait_idle(3000); check_seq("bp256", 2, base);
    rand_mode = 0;
    step();

    // key_len = 11 is rejected with a one-cycle err
    start_key(2'b11, k128);
    chk("inv_err", err, 1'b1);
    chk("inv_busy", busy, 1'b0);
    step();
    chk("inv_err_clear", err, 1'b0);
    chk("inv_busy_after", busy, 1'b0);

    // start while busy is ignored
    base = n;
    start_key(2'b00, k128);
    repeat (9) step();
    key_len = 2'b10; key = k256; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_err", err, 1'b0);
    wait_idle(3000);
    check_seq("busy_start", 0, base);

    // flush in cycle 20 of AES-128
    start_key(2'b00, k128);
    repeat (19) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_valid", rk_valid, 1'b0);
    chk("flush_last", rk_last, 1'b0);
    chk("flush_data_hold", rk_data, ref_keys[0][3]);
    step();
    base = n; start_key(2'b00, k128); wait_idle(3000); check_seq("post_flush", 0, base);

    // asynchronous reset mid-expansion
    start_key(2'b00, k128);
    repeat (14) step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_valid", rk_valid, 1'b0);
    chk("arst_data", rk_data, 128'h0);
    chk("arst_idx", rk_idx, 4'h0);
    chk("arst_last", rk_last, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    base = n; start_key(2'b00, k128); wait_idle(3000); check_seq("post_arst", 0, base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
